ex_muldiv_unit: RTL and testbench



---
 rtl/ex_muldiv_unit.sv | 200 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit -- iterative RV64M multiply/divide unit for the EX stage.
//
// Multiplies use radix-2 shift-add on operand magnitudes, and divides use
// radix-2 restoring division on magnitudes. Signs are fixed up in the step
// that finishes the operation. Divide-by-zero and signed overflow bypass the
// iteration and go straight to DONE.
//
// Optional feature: define MULDIV_FAST_MUL_EN to give every multiply a
// single-cycle combinational 128-bit product that takes the fast path.
// Divides stay iterative in both builds.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         EX holds an M-ext instruction with final operands
//   funct3        0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   is_word       W-variant (ignored for funct3 1..3)
//   A, B          rs1 / rs2 operands
//   flush         kill in-flight op; has priority over start
//   busy          registered, state != IDLE
//   stall_req     combinational freeze request to the hazard unit
//   valid_out     one-cycle result-valid pulse (high in DONE)
//   result        registered result, held until the next accepted op
//   o_dbg_state   current FSM state (0 IDLE, 1 CALC, 2 DONE)
module ex_muldiv_unit #(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic            is_word,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   input  logic            flush,
   output logic            busy,
   output logic            stall_req,
   output logic            valid_out,
   output logic [XLEN-1:0] result,
   output logic [1:0]      o_dbg_state
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2} state_t;

   state_t      r_state;
   logic [6:0]  r_cnt;
   logic [63:0] r_hi, r_lo, r_mc, r_result;
   logic [1:0]  r_op;
   logic        r_is_div, r_word, r_a_neg, r_b_neg, r_busy, r_valid;

   logic        w_is_div, w_word, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
   logic        w_b_zero, w_ovf, w_fast, w_ge;
   logic [63:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_fast_res;
   logic [64:0] w_sum, w_shl;
   logic [63:0] w_dif, w_hi_nx, w_lo_nx, w_q_raw, w_q, w_r, w_calc_res;
   logic [127:0] w_mul_raw;

   // W results are the sign-extended low 32 bits.
   function automatic logic [63:0] f_wfix(input logic [63:0] v, input logic word);
      return word ? {{32{v[31]}}, v[31:0]} : v;
   endfunction

   // Applies the sign to a magnitude product and picks the low or high half.
   function automatic logic [63:0] f_mul_sel(input logic [127:0] raw, input logic neg,
                                              input logic [1:0] op, input logic word);
      logic [127:0] p;
      p = neg ? (~raw + 128'd1) : raw;
      return (op == 2'b00) ? f_wfix(p[63:0], word) : p[127:64];
   endfunction

   // Decode of the live inputs, used only while IDLE.
   always_comb begin
      w_is_div = funct3[2];
      w_word   = is_word & (funct3[2] | (funct3[1:0] == 2'b00));
      w_a_sgn  = (funct3 == 3'd0) | (funct3 == 3'd1) | (funct3 == 3'd2) |
                 (funct3 == 3'd4) | (funct3 == 3'd6);
      w_b_sgn  = (funct3 == 3'd0) | (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
      w_a_ext  = w_word ? (w_a_sgn ? {{32{A[31]}}, A[31:0]} : {32'b0, A[31:0]}) : A;
      w_b_ext  = w_word ? (w_b_sgn ? {{32{B[31]}}, B[31:0]} : {32'b0, B[31:0]}) : B;
      w_a_neg  = w_a_sgn & w_a_ext[63];
      w_b_neg  = w_b_sgn & w_b_ext[63];
      w_a_mag  = w_a_neg ? (~w_a_ext + 64'd1) : w_a_ext;
      w_b_mag  = w_b_neg ? (~w_b_ext + 64'd1) : w_b_ext;
      w_b_zero = (w_b_ext == 64'd0);
      // Most-negative / -1 at the operating width; sign extension makes the
      // W case a 64-bit compare as well.
      w_ovf    = w_a_sgn & (w_b_ext == 64'hFFFF_FFFF_FFFF_FFFF) &
                 (w_a_ext == (w_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
      w_fast     = 1'b0;
      w_fast_res = 64'd0;
      if (w_is_div) begin
         w_fast = w_b_zero | w_ovf;
         if (w_b_zero)
            w_fast_res = funct3[1] ? f_wfix(w_a_ext, w_word) : 64'hFFFF_FFFF_FFFF_FFFF;
         else
            w_fast_res = funct3[1] ? 64'd0 : f_wfix(w_a_ext, w_word);
      end
`ifdef MULDIV_FAST_MUL_EN
      else begin
         w_fast     = 1'b1;
         w_fast_res = f_mul_sel(128'(w_a_mag) * 128'(w_b_mag), w_a_neg ^ w_b_neg,
                                funct3[1:0], w_word);
      end
`endif
   end

   // One radix-2 step from the registered datapath, plus the final result in
   // case this is the last step.
   always_comb begin
      w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mc} : 65'd0);
      w_shl = {r_hi, r_lo[63]};
      w_ge  = (w_shl >= {1'b0, r_mc});
      w_dif = w_shl[63:0] - r_mc;
      if (r_is_div) begin
         w_hi_nx = w_ge ? w_dif : w_shl[63:0];
         w_lo_nx = {r_lo[62:0], w_ge};
      end else begin
         w_hi_nx = w_sum[64:1];
         w_lo_nx = {w_sum[0], r_lo[63:1]};
      end
      // A 32-step multiply leaves the product shifted up by 32 bits.
      w_mul_raw  = r_word ? {64'b0, w_hi_nx[31:0], w_lo_nx[63:32]} : {w_hi_nx, w_lo_nx};
      w_q_raw    = r_word ? {32'b0, w_lo_nx[31:0]} : w_lo_nx;
      w_q        = (r_a_neg ^ r_b_neg) ? (~w_q_raw + 64'd1) : w_q_raw;
      w_r        = r_a_neg ? (~w_hi_nx + 64'd1) : w_hi_nx;
      w_calc_res = r_is_div ? f_wfix(r_op[1] ? w_r : w_q, r_word)
                            : f_mul_sel(w_mul_raw, r_a_neg ^ r_b_neg, r_op, r_word);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 7'd0;
         r_hi     <= 64'd0;
         r_lo     <= 64'd0;
         r_mc     <= 64'd0;
         r_result <= 64'd0;
         r_op     <= 2'd0;
         r_is_div <= 1'b0;
         r_word   <= 1'b0;
         r_a_neg  <= 1'b0;
         r_b_neg  <= 1'b0;
         r_busy   <= 1'b0;
         r_valid  <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start && !flush) begin
                  r_op     <= funct3[1:0];
                  r_is_div <= w_is_div;
                  r_word   <= w_word;
                  r_a_neg  <= w_a_neg;
                  r_b_neg  <= w_b_neg;
                  r_cnt    <= w_word ? 7'd32 : 7'd64;
                  r_hi     <= 64'd0;
                  r_busy   <= 1'b1;
                  // Multiply: multiplicand in r_mc, multiplier shifts out of r_lo.
                  // Divide: divisor in r_mc, dividend MSB-aligned in r_lo.
                  r_mc     <= w_is_div ? w_b_mag : w_a_mag;
                  r_lo     <= w_is_div ? (w_word ? {w_a_mag[31:0], 32'b0} : w_a_mag) : w_b_mag;
                  if (w_fast) begin
                     r_result <= w_fast_res;
                     r_valid  <= 1'b1;
                     r_state  <= S_DONE;
                  end else begin
                     r_state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (flush) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_hi  <= w_hi_nx;
                  r_lo  <= w_lo_nx;
                  r_cnt <= r_cnt - 7'd1;
                  if (r_cnt == 7'd1) begin
                     r_result <= w_calc_res;
                     r_valid  <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Low in DONE so the pipeline advances in the cycle the result is captured.
   assign stall_req   = ((r_state == S_IDLE) & start & ~flush) | (r_state == S_CALC);
   assign busy        = r_busy;
   assign valid_out   = r_valid;
   assign result      = r_result;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Testbench for ex_muldiv_unit: directed cases followed by random operations,
// each compared against a behavioural model using plain wide-integer arithmetic.
module tb_ex_muldiv_unit;

   logic        clk, rst, start, is_word, flush;
   logic [2:0]  funct3;
   logic [63:0] A, B, result;
   logic        busy, stall_req, valid_out;
   logic [1:0]  dbg_state;
   int          n_vec = 0;
   int          n_err = 0;

   ex_muldiv_unit #(.XLEN(64)) dut (
      .clk(clk), .rst(rst), .start(start), .funct3(funct3), .is_word(is_word),
      .A(A), .B(B), .flush(flush), .busy(busy), .stall_req(stall_req),
      .valid_out(valid_out), .result(result), .o_dbg_state(dbg_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference result computed with wide signed arithmetic.
   function automatic logic [63:0] model_res(input logic [2:0] f, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
      logic signed [129:0] pa, pb, p;
      logic signed [65:0]  da, db, q, r, dmin, mone;
      logic                ww, sa, sb;
      logic [63:0]         res;
      ww = w && (f == 3'd0 || f >= 3'd4);
      sa = (f == 3'd0 || f == 3'd1 || f == 3'd2 || f == 3'd4 || f == 3'd6);
      sb = (f == 3'd0 || f == 3'd1 || f == 3'd4 || f == 3'd6);
      if (f < 3'd4) begin
         pa  = sa ? {{66{a[63]}}, a} : {66'b0, a};
         pb  = sb ? {{66{b[63]}}, b} : {66'b0, b};
         p   = pa * pb;
         res = (f == 3'd0) ? (ww ? {{32{p[31]}}, p[31:0]} : p[63:0]) : p[127:64];
      end else begin
         if (ww) begin
            da = sa ? {{34{a[31]}}, a[31:0]} : {34'b0, a[31:0]};
            db = sa ? {{34{b[31]}}, b[31:0]} : {34'b0, b[31:0]};
            dmin = -(66'sd1 <<< 31);
         end else begin
            da = sa ? {{2{a[63]}}, a} : {2'b0, a};
            db = sa ? {{2{b[63]}}, b} : {2'b0, b};
            dmin = -(66'sd1 <<< 63);
         end
         mone = -66'sd1;
         if (db == 66'sd0) begin
            q = mone; r = da;
         end else if (sa && db == mone && da == dmin) begin
            q = da; r = 66'sd0;
         end else begin
            q = da / db; r = da % db;
         end
         res = f[1] ? r[63:0] : q[63:0];
         if (ww) res = {{32{res[31]}}, res[31:0]};
      end
      return res;
   endfunction

   // Cycles from the start-sampling edge until the valid_out cycle.
   function automatic int exp_lat(input logic [2:0] f, input logic w,
                                  input logic [63:0] a, input logic [63:0] b);
      logic ww;
      ww = w && (f == 3'd0 || f >= 3'd4);
      if (f >= 3'd4) begin
         if (ww ? (b[31:0] == 32'd0) : (b == 64'd0)) return 1;
         if ((f == 3'd4 || f == 3'd6) &&
             (ww ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                 : (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)))
            return 1;
         return ww ? 33 : 65;
      end
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return ww ? 33 : 65;
`endif
   endfunction

   function automatic logic [63:0] rnd64();
      logic [63:0] v;
      case ($urandom_range(0, 4))
         0: v = {$urandom, $urandom};
         1: v = 64'($urandom_range(0, 100));
         2: v = -64'($urandom_range(1, 100));
         3: case ($urandom_range(0, 5))
               0: v = 64'd0;
               1: v = 64'hFFFF_FFFF_FFFF_FFFF;
               2: v = 64'h8000_0000_0000_0000;
               3: v = 64'h0000_0000_8000_0000;
               4: v = 64'h0000_0000_FFFF_FFFF;
               default: v = 64'd1;
            endcase
         default: begin
            v = {$urandom, $urandom};
            v[63:32] = v[31] ? 32'hFFFF_FFFF : 32'd0;
         end
      endcase
      return v;
   endfunction

   task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_res);
      int lat, k;
      lat = exp_lat(f, w, a, b);
      @(negedge clk);
      start = 1'b1; funct3 = f; is_word = w; A = a; B = b;
      #1 check({tag, " stall_idle"}, 64'(stall_req), 64'd1);
      @(negedge clk);
      // Scramble the inputs: the unit must work from its latched copies.
      start = 1'b0; funct3 = 3'($urandom); is_word = 1'($urandom);
      A = {$urandom, $urandom}; B = {$urandom, $urandom};
      k = 1;
      while (valid_out !== 1'b1 && k < 200) begin
         check({tag, " stall_calc"}, 64'(stall_req), 64'd1);
         @(negedge clk);
         k++;
      end
      check({tag, " latency"}, 64'(k), 64'(lat));
      check({tag, " result"}, result, exp_res);
      check({tag, " stall_done"}, 64'(stall_req), 64'd0);
      check({tag, " busy_done"}, 64'(busy), 64'd1);
      @(negedge clk);
      check({tag, " valid_drop"}, 64'(valid_out), 64'd0);
      check({tag, " busy_idle"}, 64'(busy), 64'd0);
      check({tag, " result_hold"}, result, exp_res);
   endtask

   initial begin
      int pulses;
      logic [2:0]  rf;
      logic        rw;
      logic [63:0] ra, rb;

      rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'd0; is_word = 1'b0;
      A = 64'd0; B = 64'd0;
      repeat (3) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset stall", 64'(stall_req), 64'd0);
      check("reset valid", 64'(valid_out), 64'd0);
      check("reset result", result, 64'd0);
      check("reset state", 64'(dbg_state), 64'd0);
      rst = 1'b0;

      run_op("mul", 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
      run_op("mulhu", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFE);
      run_op("mulhsu", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("mulh_min", 3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
             64'h4000_0000_0000_0000);
      run_op("mulw", 3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
      run_op("div", 3'd4, 1'b0, -64'd20, 64'd3, -64'd6);
      run_op("rem", 3'd6, 1'b0, -64'd20, 64'd3, -64'd2);
      run_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_8000_0000);
      run_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
             64'h8000_0000_0000_0000);
      run_op("divu_z", 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      run_op("remu_z", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5);
      run_op("divuw", 3'd5, 1'b1, 64'd100, 64'd7, 64'd14);
      run_op("remw", 3'd6, 1'b1, -64'd100, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE);

      // Flush in cycle t0+10 of a divide.
      @(negedge clk);
      start = 1'b1; funct3 = 3'd4; is_word = 1'b0; A = -64'd20; B = 64'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush busy", 64'(busy), 64'd0);
      check("flush stall", 64'(stall_req), 64'd0);
      check("flush valid", 64'(valid_out), 64'd0);
      pulses = 0;
      for (int i = 0; i < 70; i++) begin
         @(negedge clk);
         if (valid_out === 1'b1) pulses++;
      end
      check("flush no_pulse", 64'(pulses), 64'd0);

      // Flush beats start in IDLE.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; funct3 = 3'd5; A = 64'd9; B = 64'd0;
      #1 check("flushstart stall", 64'(stall_req), 64'd0);
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      check("flushstart busy", 64'(busy), 64'd0);
      check("flushstart valid", 64'(valid_out), 64'd0);

      // Reset in cycle t0+5 of a multiply.
      @(negedge clk);
      start = 1'b1; funct3 = 3'd0; is_word = 1'b0; A = 64'd3; B = 64'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst busy", 64'(busy), 64'd0);
      check("midrst stall", 64'(stall_req), 64'd0);
      check("midrst valid", 64'(valid_out), 64'd0);
      check("midrst result", result, 64'd0);
      run_op("after_rst", 3'd0, 1'b0, 64'd3, 64'd4, 64'd12);

      for (int i = 0; i < 40; i++) begin
         rf = 3'($urandom_range(0, 7));
         rw = 1'($urandom_range(0, 1));
         ra = rnd64();
         rb = rnd64();
         run_op("rand", rf, rw, ra, rb, model_res(rf, rw, ra, rb));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
